// File: rtl/l1tlb_l2req_tracker_pkg.sv
// Shared types for the L1TLB <-> L2TLB miss-tracking path.
package l1tlb_l2req_tracker_pkg;

  localparam int L1TLB_NREQ   = 4;
  // rid field width in every message; wide enough for NREQ up to 16 and for
  // snoop rids that are not entry rids at all (they are only echoed in the sack)
  localparam int L1TLB_RID_FW = 4;

  typedef logic [11:0]             SC_hpaddr_type;
  typedef logic [11:0]             SC_ppaddr_type;
  typedef logic [7:0]              SC_dctlbe_type;
  typedef logic [L1TLB_RID_FW-1:0] SC_rid_type;

  typedef struct packed {
    SC_rid_type    rid;
    SC_hpaddr_type hpaddr;
  } I_l1tlbtol2tlb_req_type;

  typedef struct packed {
    SC_rid_type    rid;
    SC_hpaddr_type hpaddr;
    SC_ppaddr_type ppaddr;
    SC_dctlbe_type dctlbe;
  } I_l2tlbtol1tlb_ack_type;

  typedef struct packed {
    SC_rid_type    rid;
    SC_hpaddr_type hpaddr;
  } I_l2tlbtol1tlb_snoop_type;

  typedef struct packed {
    SC_rid_type rid;
  } I_l1tlbtol2tlb_sack_type;

  // payload carried by the fill output stage
  typedef struct packed {
    SC_hpaddr_type hpaddr;
    SC_ppaddr_type ppaddr;
    SC_dctlbe_type dctlbe;
  } L1TLB_fill_type;

endpackage

// File: rtl/l1tlb_l2req_tracker_fflop.sv
// Single-entry valid/retry output register. Loads whenever it is empty or its
// current contents leave this cycle, so a stream can pass at full rate.
module l1tlb_fflop #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         din_valid,
  output logic         din_retry,
  input  logic [W-1:0] din,
  output logic         dout_valid,
  input  logic         dout_retry,
  output logic [W-1:0] dout
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign din_retry  = valid_reg && dout_retry;
  assign dout_valid = valid_reg;
  assign dout       = data_reg;

  // hold while the consumer retries, otherwise take the next input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (!din_retry) begin
      valid_reg <= din_valid;
      if (din_valid) data_reg <= din;
    end
  end

endmodule

// File: rtl/l1tlb_l2req_tracker_prio_enc.sv
// Lowest-index select: returns the index of the lowest set request bit.
module l1tlb_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan from the top so the lowest set bit wins
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/l1tlb_l2req_tracker.sv
// L1TLB miss tracker: allocates rids for misses, issues L2TLB requests, turns
// acks into L1TLB fills, and handles L2TLB snoops (invalidate + cancel + sack).
module l1tlb_l2req_tracker
  import l1tlb_l2req_tracker_pkg::*;
#(
  parameter int NREQ  = L1TLB_NREQ,
  parameter int RID_W = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_valid,
  output logic                     miss_retry,
  input  SC_hpaddr_type            miss_hpaddr,
  output logic                     fill_valid,
  input  logic                     fill_retry,
  output SC_hpaddr_type            fill_hpaddr,
  output SC_ppaddr_type            fill_ppaddr,
  output SC_dctlbe_type            fill_dctlbe,
  output logic                     inv_valid,
  output SC_hpaddr_type            inv_hpaddr,
  output logic                     l1tlbtol2tlb_req_valid,
  input  logic                     l1tlbtol2tlb_req_retry,
  output I_l1tlbtol2tlb_req_type   l1tlbtol2tlb_req,
  input  logic                     l2tlbtol1tlb_ack_valid,
  output logic                     l2tlbtol1tlb_ack_retry,
  input  I_l2tlbtol1tlb_ack_type   l2tlbtol1tlb_ack,
  input  logic                     l2tlbtol1tlb_snoop_valid,
  output logic                     l2tlbtol1tlb_snoop_retry,
  input  I_l2tlbtol1tlb_snoop_type l2tlbtol1tlb_snoop,
  output logic                     l1tlbtol2tlb_sack_valid,
  input  logic                     l1tlbtol2tlb_sack_retry,
  output I_l1tlbtol2tlb_sack_type  l1tlbtol2tlb_sack
);

  typedef enum logic [1:0] {FREE, SEND, WAIT, FILL} ent_state_e;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [NREQ-1:0] free_vec, send_vec, fill_vec, merge_vec, snoop_vec;
  logic [NREQ-1:0] alloc_vec, req_take_vec, ack_vec, fill_take_vec;
  SC_hpaddr_type   ent_hpaddr [NREQ];
  SC_ppaddr_type   ent_ppaddr [NREQ];
  SC_dctlbe_type   ent_dctlbe [NREQ];

  logic             alloc_any, send_any, fill_any;
  logic [RID_W-1:0] alloc_idx, send_idx, fill_idx, ack_idx;
  logic             miss_fire, merge_hit, snoop_fire, ack_rid_ok, ack_matched;
  logic             req_din_retry, fill_din_retry, sack_din_retry;
  logic             sack_pend_reg, inv_valid_reg;
  SC_rid_type       sack_rid_reg;
  SC_hpaddr_type    inv_hpaddr_reg;
  I_l1tlbtol2tlb_req_type  req_din;
  I_l1tlbtol2tlb_sack_type sack_din;
  L1TLB_fill_type          fill_din, fill_dout;

  // ---------------- global decode ----------------
  assign snoop_fire = l2tlbtol1tlb_snoop_valid && !l2tlbtol1tlb_snoop_retry;
  assign merge_hit  = |merge_vec;
  assign miss_retry = !merge_hit && !alloc_any;
  assign miss_fire  = miss_valid && !miss_retry;
  assign alloc_vec  = (miss_fire && !merge_hit) ? (ONE << alloc_idx) : '0;

  assign ack_idx     = l2tlbtol1tlb_ack.rid[RID_W-1:0];
  assign ack_rid_ok  = (l2tlbtol1tlb_ack.rid >> RID_W) == '0;
  assign ack_matched = |ack_vec;
  assign l2tlbtol1tlb_ack_retry = 1'b0;

  assign req_take_vec  = (send_any && !req_din_retry) ? (ONE << send_idx) : '0;
  assign fill_take_vec = (fill_any && !fill_din_retry) ? (ONE << fill_idx) : '0;

  l1tlb_prio_enc #(.N(NREQ), .IW(RID_W)) u_alloc_enc (.req(free_vec), .idx(alloc_idx), .any(alloc_any));
  l1tlb_prio_enc #(.N(NREQ), .IW(RID_W)) u_send_enc  (.req(send_vec), .idx(send_idx),  .any(send_any));
  l1tlb_prio_enc #(.N(NREQ), .IW(RID_W)) u_fill_enc  (.req(fill_vec), .idx(fill_idx),  .any(fill_any));

  // ---------------- per-entry FSMs ----------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ent
    ent_state_e    state_reg, state_next;
    logic          stale_reg, stale_next;
    SC_hpaddr_type hpaddr_reg, hpaddr_next;
    SC_ppaddr_type ppaddr_reg, ppaddr_next;
    SC_dctlbe_type dctlbe_reg, dctlbe_next;
    logic          is_free, is_send, is_live, is_fillable;

    // state register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_reg  <= FREE;
        stale_reg  <= 1'b0;
        hpaddr_reg <= '0;
        ppaddr_reg <= '0;
        dctlbe_reg <= '0;
      end else begin
        state_reg  <= state_next;
        stale_reg  <= stale_next;
        hpaddr_reg <= hpaddr_next;
        ppaddr_reg <= ppaddr_next;
        dctlbe_reg <= dctlbe_next;
      end
    end

    // next state: a stale entry in FILL is dropped without producing a fill
    always_comb begin
      state_next  = state_reg;
      stale_next  = stale_reg;
      hpaddr_next = hpaddr_reg;
      ppaddr_next = ppaddr_reg;
      dctlbe_next = dctlbe_reg;
      case (state_reg)
        FREE: if (alloc_vec[gi]) begin
          state_next  = SEND;
          stale_next  = 1'b0;
          hpaddr_next = miss_hpaddr;
        end
        SEND: if (req_take_vec[gi]) state_next = WAIT;
        WAIT: if (ack_vec[gi]) begin
          state_next  = FILL;
          ppaddr_next = l2tlbtol1tlb_ack.ppaddr;
          dctlbe_next = l2tlbtol1tlb_ack.dctlbe;
        end
        FILL: if (stale_reg || fill_take_vec[gi]) state_next = FREE;
        default: state_next = FREE;
      endcase
      if (snoop_vec[gi]) stale_next = 1'b1;
    end

    // entry status decode
    always_comb begin
      is_free     = (state_reg == FREE);
      is_send     = (state_reg == SEND);
      is_live     = (state_reg != FREE);
      // a fill for a page being snooped this cycle must not reach the array
      is_fillable = (state_reg == FILL) && !stale_reg &&
                    !(snoop_fire && hpaddr_reg == l2tlbtol1tlb_snoop.hpaddr);
    end

    assign free_vec[gi]  = is_free;
    assign send_vec[gi]  = is_send;
    assign fill_vec[gi]  = is_fillable;
    assign snoop_vec[gi] = snoop_fire && is_live && (hpaddr_reg == l2tlbtol1tlb_snoop.hpaddr);
    // a snoop in the same cycle wins, so the miss then allocates a fresh entry
    assign merge_vec[gi] = is_live && !stale_reg && (hpaddr_reg == miss_hpaddr) && !snoop_vec[gi];
    assign ack_vec[gi]   = l2tlbtol1tlb_ack_valid && ack_rid_ok &&
                           (ack_idx == RID_W'(gi)) && (state_reg == WAIT);
    assign ent_hpaddr[gi] = hpaddr_reg;
    assign ent_ppaddr[gi] = ppaddr_reg;
    assign ent_dctlbe[gi] = dctlbe_reg;
  end

  // ---------------- request output ----------------
  always_comb begin
    req_din.rid    = L1TLB_RID_FW'(send_idx);
    req_din.hpaddr = ent_hpaddr[send_idx];
  end

  l1tlb_fflop #(.W($bits(I_l1tlbtol2tlb_req_type))) u_req_ff (
    .clk, .reset,
    .din_valid(send_any), .din_retry(req_din_retry), .din(req_din),
    .dout_valid(l1tlbtol2tlb_req_valid), .dout_retry(l1tlbtol2tlb_req_retry),
    .dout(l1tlbtol2tlb_req)
  );

  // ---------------- fill output ----------------
  always_comb begin
    fill_din.hpaddr = ent_hpaddr[fill_idx];
    fill_din.ppaddr = ent_ppaddr[fill_idx];
    fill_din.dctlbe = ent_dctlbe[fill_idx];
  end

  l1tlb_fflop #(.W($bits(L1TLB_fill_type))) u_fill_ff (
    .clk, .reset,
    .din_valid(fill_any), .din_retry(fill_din_retry), .din(fill_din),
    .dout_valid(fill_valid), .dout_retry(fill_retry), .dout(fill_dout)
  );

  assign fill_hpaddr = fill_dout.hpaddr;
  assign fill_ppaddr = fill_dout.ppaddr;
  assign fill_dctlbe = fill_dout.dctlbe;

  // ---------------- snoop: invalidate pulse and sack ----------------
  // only one snoop in flight: blocked while its sack is queued or presented
  assign l2tlbtol1tlb_snoop_retry = sack_pend_reg || l1tlbtol2tlb_sack_valid;
  assign inv_valid  = inv_valid_reg;
  assign inv_hpaddr = inv_hpaddr_reg;
  assign sack_din.rid = sack_rid_reg;

  // one-cycle invalidate and pending-sack capture for an accepted snoop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_valid_reg  <= 1'b0;
      inv_hpaddr_reg <= '0;
      sack_pend_reg  <= 1'b0;
      sack_rid_reg   <= '0;
    end else begin
      inv_valid_reg <= snoop_fire;
      if (snoop_fire) begin
        inv_hpaddr_reg <= l2tlbtol1tlb_snoop.hpaddr;
        sack_pend_reg  <= 1'b1;
        sack_rid_reg   <= l2tlbtol1tlb_snoop.rid;
      end else if (!sack_din_retry) begin
        sack_pend_reg  <= 1'b0;
      end
    end
  end

  l1tlb_fflop #(.W($bits(I_l1tlbtol2tlb_sack_type))) u_sack_ff (
    .clk, .reset,
    .din_valid(sack_pend_reg), .din_retry(sack_din_retry), .din(sack_din),
    .dout_valid(l1tlbtol2tlb_sack_valid), .dout_retry(l1tlbtol2tlb_sack_retry),
    .dout(l1tlbtol2tlb_sack)
  );

  // an ack must target a WAIT entry with the page that entry requested
  a_ack_to_wait: assert property (@(posedge clk) disable iff (reset)
    l2tlbtol1tlb_ack_valid |-> (ack_matched && ent_hpaddr[ack_idx] == l2tlbtol1tlb_ack.hpaddr));

endmodule

// File: tb/tb_l1tlb_l2req_tracker.sv
// Scoreboard bench for l1tlb_l2req_tracker: directed stimulus pushes expected
// req/fill/inv/sack items; negedge monitors pop and compare on each transfer.
module tb_l1tlb_l2req_tracker;
  import l1tlb_l2req_tracker_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic miss_valid, miss_retry;
  SC_hpaddr_type miss_hpaddr;
  logic fill_valid, fill_retry;
  SC_hpaddr_type fill_hpaddr;
  SC_ppaddr_type fill_ppaddr;
  SC_dctlbe_type fill_dctlbe;
  logic inv_valid;
  SC_hpaddr_type inv_hpaddr;
  logic req_valid, req_retry;
  I_l1tlbtol2tlb_req_type req;
  logic ack_valid, ack_retry;
  I_l2tlbtol1tlb_ack_type ack;
  logic snoop_valid, snoop_retry;
  I_l2tlbtol1tlb_snoop_type snoop;
  logic sack_valid, sack_retry;
  I_l1tlbtol2tlb_sack_type sack;

  always #5 clk = ~clk;

  l1tlb_l2req_tracker dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_retry(miss_retry), .miss_hpaddr(miss_hpaddr),
    .fill_valid(fill_valid), .fill_retry(fill_retry), .fill_hpaddr(fill_hpaddr),
    .fill_ppaddr(fill_ppaddr), .fill_dctlbe(fill_dctlbe),
    .inv_valid(inv_valid), .inv_hpaddr(inv_hpaddr),
    .l1tlbtol2tlb_req_valid(req_valid), .l1tlbtol2tlb_req_retry(req_retry),
    .l1tlbtol2tlb_req(req),
    .l2tlbtol1tlb_ack_valid(ack_valid), .l2tlbtol1tlb_ack_retry(ack_retry),
    .l2tlbtol1tlb_ack(ack),
    .l2tlbtol1tlb_snoop_valid(snoop_valid), .l2tlbtol1tlb_snoop_retry(snoop_retry),
    .l2tlbtol1tlb_snoop(snoop),
    .l1tlbtol2tlb_sack_valid(sack_valid), .l1tlbtol2tlb_sack_retry(sack_retry),
    .l1tlbtol2tlb_sack(sack)
  );

  int checks = 0;
  int passes = 0;

  I_l1tlbtol2tlb_req_type exp_req_q[$];
  L1TLB_fill_type         exp_fill_q[$];
  SC_hpaddr_type          exp_inv_q[$];
  SC_rid_type             exp_sack_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got 0x%0h required no transfer", name, act);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (req_valid && !req_retry) begin
        if (exp_req_q.size() == 0) unexpected("req_unexpected", 32'(req));
        else chk("req", 32'(req), 32'(exp_req_q.pop_front()));
        $display("req  rid=%0d hp=0x%0h", req.rid, req.hpaddr);
      end
      if (fill_valid && !fill_retry) begin
        if (exp_fill_q.size() == 0) unexpected("fill_unexpected", {fill_hpaddr, fill_ppaddr, fill_dctlbe});
        else chk("fill", {fill_hpaddr, fill_ppaddr, fill_dctlbe}, 32'(exp_fill_q.pop_front()));
        $display("fill hp=0x%0h pp=0x%0h dc=0x%0h", fill_hpaddr, fill_ppaddr, fill_dctlbe);
      end
      if (inv_valid) begin
        if (exp_inv_q.size() == 0) unexpected("inv_unexpected", 32'(inv_hpaddr));
        else chk("inv", 32'(inv_hpaddr), 32'(exp_inv_q.pop_front()));
        $display("inv  hp=0x%0h", inv_hpaddr);
      end
      if (sack_valid && !sack_retry) begin
        if (exp_sack_q.size() == 0) unexpected("sack_unexpected", 32'(sack.rid));
        else chk("sack", 32'(sack.rid), 32'(exp_sack_q.pop_front()));
        $display("sack rid=%0d", sack.rid);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int rid, input logic [11:0] hp);
    I_l1tlbtol2tlb_req_type r;
    r.rid = SC_rid_type'(rid);
    r.hpaddr = hp;
    exp_req_q.push_back(r);
  endtask

  task automatic push_fill(input logic [11:0] hp, input logic [11:0] pp, input logic [7:0] dc);
    L1TLB_fill_type f;
    f.hpaddr = hp;
    f.ppaddr = pp;
    f.dctlbe = dc;
    exp_fill_q.push_back(f);
  endtask

  // present a miss and hold it until accepted (bounded)
  task automatic do_miss(input logic [11:0] hp);
    int n;
    n = 0;
    miss_valid = 1'b1;
    miss_hpaddr = hp;
    @(negedge clk);
    while (miss_retry && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (miss_retry) begin
      checks++;
      $display("FAIL miss_accept_timeout: got retry=1 required accept of 0x%0h", hp);
    end
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
  endtask

  task automatic do_ack(input int rid, input logic [11:0] hp, input logic [11:0] pp, input logic [7:0] dc);
    ack_valid = 1'b1;
    ack.rid = SC_rid_type'(rid);
    ack.hpaddr = hp;
    ack.ppaddr = pp;
    ack.dctlbe = dc;
    @(negedge clk);
    chk("ack_retry", 32'(ack_retry), 32'd0);
    @(posedge clk);
    #1;
    ack_valid = 1'b0;
  endtask

  task automatic do_snoop(input int rid, input logic [11:0] hp);
    int n;
    n = 0;
    snoop_valid = 1'b1;
    snoop.rid = SC_rid_type'(rid);
    snoop.hpaddr = hp;
    @(negedge clk);
    while (snoop_retry && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (snoop_retry) begin
      checks++;
      $display("FAIL snoop_accept_timeout: got retry=1 required accept");
    end
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    miss_valid = 1'b0; miss_hpaddr = '0;
    fill_retry = 1'b0; req_retry = 1'b0; sack_retry = 1'b0;
    ack_valid = 1'b0; ack = '0;
    snoop_valid = 1'b0; snoop = '0;
    tick(2);
    // reset state
    chk("rst_req_valid",   32'(req_valid),   32'd0);
    chk("rst_fill_valid",  32'(fill_valid),  32'd0);
    chk("rst_inv_valid",   32'(inv_valid),   32'd0);
    chk("rst_sack_valid",  32'(sack_valid),  32'd0);
    chk("rst_miss_retry",  32'(miss_retry),  32'd0);
    chk("rst_ack_retry",   32'(ack_retry),   32'd0);
    chk("rst_snoop_retry", 32'(snoop_retry), 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: single miss, ack, fill
    push_req(0, 12'h1A5);
    push_fill(12'h1A5, 12'h003, 8'h10);
    do_miss(12'h1A5);
    tick(4);
    do_ack(0, 12'h1A5, 12'h003, 8'h10);
    tick(4);

    // 2: duplicate miss merges; two reqs, two fills
    push_req(0, 12'h010);
    push_req(1, 12'h020);
    push_fill(12'h010, 12'h011, 8'h01);
    push_fill(12'h020, 12'h022, 8'h02);
    do_miss(12'h010);
    do_miss(12'h010);
    do_miss(12'h020);
    tick(4);
    do_ack(0, 12'h010, 12'h011, 8'h01);
    do_ack(1, 12'h020, 12'h022, 8'h02);
    tick(4);

    // 3: four outstanding, fifth miss retried until a fill frees rid2
    for (int i = 0; i < 4; i++) push_req(i, 12'h100 + 12'(i));
    for (int i = 0; i < 4; i++) do_miss(12'h100 + 12'(i));
    tick(6);
    miss_valid = 1'b1;
    miss_hpaddr = 12'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_miss_retry", 32'(miss_retry), 32'd1);
      @(posedge clk);
      #1;
    end
    push_fill(12'h102, 12'h202, 8'h22);
    push_req(2, 12'h104);
    do_ack(2, 12'h102, 12'h202, 8'h22);
    do_miss(12'h104);
    tick(4);
    push_fill(12'h100, 12'h200, 8'h20);
    push_fill(12'h101, 12'h201, 8'h21);
    push_fill(12'h103, 12'h203, 8'h23);
    push_fill(12'h104, 12'h204, 8'h24);
    do_ack(0, 12'h100, 12'h200, 8'h20); tick(3);
    do_ack(1, 12'h101, 12'h201, 8'h21); tick(3);
    do_ack(3, 12'h103, 12'h203, 8'h23); tick(3);
    do_ack(2, 12'h104, 12'h204, 8'h24); tick(4);

    // 4: snoop cancels an in-flight miss; later ack produces no fill
    push_req(0, 12'h044);
    do_miss(12'h044);
    tick(4);
    exp_inv_q.push_back(12'h044);
    exp_sack_q.push_back(SC_rid_type'(5));
    do_snoop(5, 12'h044);
    tick(4);
    do_ack(0, 12'h044, 12'h0AA, 8'hAA);
    tick(4);

    // 5: fills held under fill_retry, then lowest index first
    push_req(0, 12'h050);
    push_req(1, 12'h051);
    push_req(2, 12'h052);
    push_fill(12'h051, 12'h151, 8'h51);
    push_fill(12'h050, 12'h150, 8'h50);
    push_fill(12'h052, 12'h152, 8'h52);
    do_miss(12'h050);
    do_miss(12'h051);
    do_miss(12'h052);
    tick(5);
    fill_retry = 1'b1;
    do_ack(1, 12'h051, 12'h151, 8'h51);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fill_hold_valid", 32'(fill_valid), 32'd1);
      chk("fill_hold_hp", 32'(fill_hpaddr), 32'h051);
      @(posedge clk);
      #1;
    end
    do_ack(2, 12'h052, 12'h152, 8'h52);
    do_ack(0, 12'h050, 12'h150, 8'h50);
    tick(2);
    fill_retry = 1'b0;
    tick(6);

    // 6: reset with two WAIT entries and a sack pending
    push_req(0, 12'h060);
    push_req(1, 12'h061);
    do_miss(12'h060);
    do_miss(12'h061);
    tick(5);
    sack_retry = 1'b1;
    exp_inv_q.push_back(12'h099);
    do_snoop(7, 12'h099);
    tick(3);
    @(negedge clk);
    chk("sack_pending", 32'(sack_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_sack_valid", 32'(sack_valid), 32'd0);
    chk("async_rst_req_valid",  32'(req_valid),  32'd0);
    chk("async_rst_fill_valid", 32'(fill_valid), 32'd0);
    chk("async_rst_inv_valid",  32'(inv_valid),  32'd0);
    chk("async_rst_snoop_retry", 32'(snoop_retry), 32'd0);
    tick(2);
    sack_retry = 1'b0;
    reset = 1'b0;
    tick(2);
    push_req(0, 12'h070);
    push_fill(12'h070, 12'h170, 8'h70);
    do_miss(12'h070);
    tick(4);
    do_ack(0, 12'h070, 12'h170, 8'h70);
    tick(6);

    chk("req_q_drained",  32'(exp_req_q.size()),  32'd0);
    chk("fill_q_drained", 32'(exp_fill_q.size()), 32'd0);
    chk("inv_q_drained",  32'(exp_inv_q.size()),  32'd0);
    chk("sack_q_drained", 32'(exp_sack_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
